dma_bus_master: RTL and testbench
=================================

Name: dma_bus_master

Overview:
- Bus initiator for the MTL-1 6809 bus: asserts the 6809 DMA/BREQ input, waits for the bus grant (BA=1, BS=1), then drives address, data and RW itself to write a byte stream into consecutive bus addresses, normally SRAM at 0x0000-0x0FFF.
- Covers the initiator side of the same bus that the address decoder, SRAM controller and flash controller answer as responders.
- Intended use: preload SRAM from the SPI flash controller's byte stream without CPU involvement.

Parameters:
- SETUP_CLKS, 2, clocks that address/data/RW are driven before the write strobe falls.
- STROBE_CLKS, 4, clocks that o_WE is held low.
- HOLD_CLKS, 2, clocks that address/data are held after o_WE rises.
- MAX_BURST, 14, maximum bytes per bus tenure before a forced release (6809 DMA cycle-steal limit).
- GAP_CLKS, 16, minimum clocks with o_DMA high between two tenures.
- GRANT_TIMEOUT, 1024, clocks to wait for a grant before aborting.

Ports:
- clk  input  1  system clock (clk_8mhz domain)
- reset  input  1  synchronous, active-high reset
- i_start  input  1  one-cycle pulse; latches i_base_addr and i_length; ignored while o_busy=1
- i_base_addr  input  16  first bus address
- i_length  input  13  byte count, 0..4096
- i_wr_data  input  8  source byte
- i_wr_valid  input  1  source byte available
- o_wr_ready  output  1  byte consumed when i_wr_valid and o_wr_ready are both 1 on a rising clk
- i_BA  input  1  6809 bus available (asynchronous; two-flop synchronised inside)
- i_BS  input  1  6809 bus status (asynchronous; two-flop synchronised inside)
- o_DMA  output  1  active-low DMA/BREQ request to the 6809
- o_ADDRESS  output  16  driven address
- o_ADDR_OE  output  1  address bus output enable
- o_DATA  output  8  driven data
- o_DATA_OE  output  1  data bus output enable
- o_RW  output  1  driven R/W; 0 = write
- o_WE  output  1  active-low SRAM write strobe
- o_busy  output  1  transfer in progress
- o_done  output  1  one-cycle pulse at normal completion
- o_error  output  1  one-cycle pulse on grant timeout

Behaviour:
- Reset values: o_DMA=1, o_ADDR_OE=0, o_DATA_OE=0, o_RW=1, o_WE=1, o_ADDRESS=0, o_DATA=0, o_wr_ready=0, o_busy=0, o_done=0, o_error=0. Internal state is IDLE, all counters are 0.
- Reset asserted mid-operation: every output returns to its reset value on the next clk and the bus is released immediately.
- States: IDLE, FETCH, REQ, SETUP, STROBE, HOLD, NEXT, RELEASE.
- IDLE:
  - On i_start with i_length=0: o_done pulses on the next cycle, no bus request is made.
  - On i_start with i_length>0: latch base address and remaining count (rem=i_length), set o_busy=1, go to FETCH.
- FETCH: o_wr_ready=1. On the handshake, capture the byte into a data register and go to REQ; if the bus is already held, go straight to SETUP.
- REQ:
  - o_DMA=0 and the grant-wait counter runs.
  - When synchronised BA=1 and BS=1, clear the burst count and go to SETUP.
  - When the counter reaches GRANT_TIMEOUT: o_DMA=1, o_error pulses, o_busy=0, go to IDLE. The remaining count is discarded.
- SETUP: o_ADDR_OE=1, o_DATA_OE=1, o_RW=0, o_ADDRESS=base+idx, o_DATA=data register. Lasts SETUP_CLKS, then go to STROBE.
- STROBE: o_WE=0 for STROBE_CLKS, then go to HOLD.
- HOLD: o_WE=1 with address and data unchanged for HOLD_CLKS. On exit, rem is decremented, idx and the burst count are incremented, go to NEXT.
- NEXT (single cycle, o_wr_ready=1 during this cycle):
  - rem=0: go to RELEASE and finish.
  - Else if burst count = MAX_BURST, or no handshake occurs this cycle: go to RELEASE and continue later.
  - Else: capture the byte and go to SETUP. This gives back-to-back writes with no bus release.
- RELEASE:
  - o_ADDR_OE=0, o_DATA_OE=0, o_RW=1 in the first cycle; o_DMA=1.
  - Wait until GAP_CLKS have elapsed and synchronised BA=0.
  - If finishing: o_done pulses, o_busy=0, go to IDLE.
  - Else: go to FETCH. If a byte is already held from NEXT, go to REQ instead.
- Address arithmetic: 16-bit modulo. Base 0xFFFF followed by the next byte gives 0x0000. idx is 13 bits.
- Output enables never assert while o_DMA=1 or before the grant is seen. o_WE is low only in STROBE.
- The byte count of a transfer always equals the number of o_WE falling edges.

Test Plan:
- Basic write: start with base=0x0100, len=3, source always valid, BA/BS granted 3 clocks after o_DMA falls -> three o_WE pulses at 0x0100, 0x0101, 0x0102 with data 0xA0, 0xA1, 0xA2 in one tenure; o_DMA rises; o_done pulses once; o_busy ends 0.
- Burst limit: len=30 -> tenures of 14, 14 and 2 writes; o_DMA high for at least 16 clocks between tenures; addresses continuous.
- Source stall: len=4, i_wr_valid held low after the 2nd byte for 50 clocks -> bus released after 2 writes; re-request after data returns; 4 writes total; one o_done pulse.
- Grant timeout: BA held at 0 -> o_error pulses exactly 1024 clocks after o_DMA falls; o_DMA=1; no OE or o_WE activity; o_busy=0.
- Edge cases:
  - len=0 -> o_done pulses the next cycle and o_DMA never falls.
  - base=0xFFFE, len=3 -> writes at 0xFFFE, 0xFFFF, 0x0000.
  - i_start pulsed while busy -> ignored.
- Reset mid-strobe: reset asserted during STROBE -> on the next clk o_WE=1, OEs=0, o_DMA=1, o_busy=0; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/dma_bus_master.sv
// dma_bus_master: 6809 DMA initiator that writes a byte stream to consecutive bus addresses
module dma_bus_master #(
    parameter int SETUP_CLKS    = 2,
    parameter int STROBE_CLKS   = 4,
    parameter int HOLD_CLKS     = 2,
    parameter int MAX_BURST     = 14,
    parameter int GAP_CLKS      = 16,
    parameter int GRANT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [15:0] i_base_addr,
    input  logic [12:0] i_length,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic        i_BA,
    input  logic        i_BS,
    output logic        o_DMA,
    output logic [15:0] o_ADDRESS,
    output logic        o_ADDR_OE,
    output logic [7:0]  o_DATA,
    output logic        o_DATA_OE,
    output logic        o_RW,
    output logic        o_WE,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);
    localparam int CW = $clog2(GRANT_TIMEOUT + GAP_CLKS + SETUP_CLKS + STROBE_CLKS + HOLD_CLKS + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic [2:0] {IDLE, FETCH, REQ, SETUP, STROBE, HOLD, NEXT, RELEASE} state_t;
    state_t        state_q, state_d;
    logic [15:0]   base_q, base_d, addr_q, addr_d;
    logic [12:0]   rem_q, rem_d, idx_q, idx_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          have_q, have_d, fin_q, fin_d, done_q, done_d, err_q, err_d;
    logic [1:0]    ba_q, bs_q;
    logic          grant, bus_on, hs, gap_ok;
    assign grant      = ba_q[1] & bs_q[1];
    assign bus_on     = state_q inside {SETUP, STROBE, HOLD, NEXT};
    // Ready in NEXT only while bytes remain, so no byte is swallowed after the last write
    assign o_wr_ready = (state_q == FETCH) || (state_q == NEXT && rem_q != '0);
    assign hs         = i_wr_valid & o_wr_ready;
    assign gap_ok     = cnt_q >= CW'(GAP_CLKS - 1);
    assign o_DMA      = !(bus_on || state_q == REQ);
    assign o_ADDR_OE  = bus_on;
    assign o_DATA_OE  = bus_on;
    assign o_RW       = !bus_on;
    assign o_WE       = state_q != STROBE;
    assign o_ADDRESS  = addr_q;
    assign o_DATA     = data_q;
    assign o_busy     = state_q != IDLE;
    assign o_done     = done_q;
    assign o_error    = err_q;
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        burst_d = burst_q;
        cnt_d   = cnt_q + 1'b1;
        data_d  = data_q;
        have_d  = have_q;
        fin_d   = fin_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                if (i_length == '0) done_d = 1'b1;
                else begin
                    base_d  = i_base_addr;
                    rem_d   = i_length;
                    idx_d   = '0;
                    have_d  = 1'b0;
                    fin_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: if (hs) begin
                data_d  = i_wr_data;
                state_d = REQ;
            end
            REQ: if (grant) begin
                burst_d = '0;
                state_d = SETUP;
            end else if (cnt_q == CW'(GRANT_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                rem_d   = '0;
                state_d = IDLE;
            end
            SETUP:  state_d = (cnt_q == CW'(SETUP_CLKS - 1)) ? STROBE : SETUP;
            STROBE: state_d = (cnt_q == CW'(STROBE_CLKS - 1)) ? HOLD : STROBE;
            HOLD: if (cnt_q == CW'(HOLD_CLKS - 1)) begin
                rem_d   = rem_q - 1'b1;
                idx_d   = idx_q + 1'b1;
                burst_d = burst_q + 1'b1;
                state_d = NEXT;
            end
            NEXT: if (rem_q == '0) begin
                fin_d   = 1'b1;
                state_d = RELEASE;
            end else if (hs) begin
                data_d  = i_wr_data;
                have_d  = burst_q == BW'(MAX_BURST);
                state_d = (burst_q == BW'(MAX_BURST)) ? RELEASE : SETUP;
            end else begin
                have_d  = 1'b0;
                state_d = RELEASE;
            end
            RELEASE: if (gap_ok && !ba_q[1]) begin
                done_d  = fin_q;
                have_d  = 1'b0;
                state_d = fin_q ? IDLE : (have_q ? REQ : FETCH);
            end else cnt_d = gap_ok ? cnt_q : cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (state_d == SETUP) addr_d = base_d + {3'b000, idx_d};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            have_q  <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ba_q    <= '0;
            bs_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            have_q  <= have_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ba_q    <= {ba_q[0], i_BA};
            bs_q    <= {bs_q[0], i_BS};
        end
    end
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: randomized bench checking bus writes against a stream/address model
module tb_dma_bus_master;
    localparam int SETUP = 2, STROBE = 4, HOLD = 2, MAXB = 14, GAP = 16, TMO = 1024;
    logic        clk = 1'b0, reset = 1'b1, i_start = 1'b0;
    logic [15:0] i_base_addr = '0;
    logic [12:0] i_length = '0;
    logic [7:0]  i_wr_data = '0;
    logic        i_wr_valid = 1'b0, i_BA = 1'b0, i_BS = 1'b0;
    logic        o_wr_ready, o_DMA, o_ADDR_OE, o_DATA_OE, o_RW, o_WE, o_busy, o_done, o_error;
    logic [15:0] o_ADDRESS;
    logic [7:0]  o_DATA;
    dma_bus_master dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_length(i_length), .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid),
        .o_wr_ready(o_wr_ready), .i_BA(i_BA), .i_BS(i_BS), .o_DMA(o_DMA),
        .o_ADDRESS(o_ADDRESS), .o_ADDR_OE(o_ADDR_OE), .o_DATA(o_DATA), .o_DATA_OE(o_DATA_OE),
        .o_RW(o_RW), .o_WE(o_WE), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    int epoch = 0, chk_ep = 0, src_ep = 0;
    int cyc = 0, wcount = 0, k = 0, stall = 0, done_cnt = 0, err_cnt = 0, dma_falls = 0;
    int err_cyc = 0, dma_fall_cyc = 0, ten_w = 0, dma_hi = 0, we_run = 0, we_rise_cyc = 0, stable = 0;
    int lo = 0, hi = 0, grant_lat = 2, src_mode = 0;
    bit no_grant = 1'b0;
    int ten_q[$];
    logic        prev_we = 1'b1, prev_dma = 1'b1, prev_oe = 1'b0;
    logic [15:0] prev_addr = '0, m_base = '0;
    logic [7:0]  src[256];
    logic [15:0] wr_addr[64];
    logic [7:0]  wr_data[64];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // CPU side: grant a while after the request, drop BA a few clocks after release
    always @(negedge clk) begin
        if (!o_DMA) begin
            hi = 0;
            lo++;
            if (!no_grant && lo > grant_lat) begin i_BA = 1'b1; i_BS = 1'b1; end
        end else begin
            lo = 0;
            hi++;
            if (hi > 2) begin i_BA = 1'b0; i_BS = 1'b0; end
        end
    end
    // Byte source: src[k] is offered until consumed
    always @(negedge clk) begin
        if (src_ep != epoch) begin src_ep = epoch; k = 0; stall = 0; end
        if (src_mode == 2 && k == 2 && stall < 50) begin
            i_wr_valid = 1'b0;
            stall++;
        end else i_wr_valid = (src_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
        i_wr_data = src[k[7:0]];
        #1;
        if (i_wr_valid && o_wr_ready && !reset) k++;
    end
    // Bus observer: the n-th strobe must write src[n] to base+n, with protocol timing
    always @(negedge clk) begin
        logic oe_any;
        cyc++;
        if (chk_ep != epoch) begin
            chk_ep = epoch; wcount = 0; done_cnt = 0; err_cnt = 0; dma_falls = 0;
            ten_q.delete();
        end
        oe_any = o_ADDR_OE || o_DATA_OE || !o_RW || !o_WE;
        if (!reset) begin
            if (o_done) done_cnt++;
            if (o_error) begin err_cnt++; err_cyc = cyc; end
            chk("bus_inv", 32'(!oe_any || (!o_DMA && i_BA && o_ADDR_OE && o_DATA_OE && !o_RW)), 1);
            stable = (o_ADDR_OE && prev_oe && o_ADDRESS == prev_addr) ? stable + 1 : 1;
            if (o_WE && !prev_we) begin
                chk("we_len", we_run, STROBE);
                we_rise_cyc = cyc;
            end
            if (!o_WE && prev_we) begin
                chk("wr_addr", o_ADDRESS, 32'(16'(m_base + 16'(wcount))));
                chk("wr_data", o_DATA, src[wcount[7:0]]);
                chk("setup", 32'(stable >= SETUP + 1), 1);
                if (wcount < 64) begin wr_addr[wcount] = o_ADDRESS; wr_data[wcount] = o_DATA; end
                wcount++;
                ten_w++;
            end
            if (prev_oe && (!o_ADDR_OE || o_ADDRESS != prev_addr))
                chk("hold", 32'(cyc - we_rise_cyc >= HOLD + 1), 1);
            we_run = o_WE ? 0 : we_run + 1;
            if (!o_DMA && prev_dma) begin
                if (ten_q.size() > 0) chk("gap", 32'(dma_hi >= GAP), 1);
                dma_falls++;
                dma_fall_cyc = cyc;
                ten_w = 0;
            end
            if (o_DMA && !prev_dma) begin
                chk("burst_max", 32'(ten_w <= MAXB), 1);
                ten_q.push_back(ten_w);
            end
            dma_hi = o_DMA ? dma_hi + 1 : 0;
        end
        prev_we = o_WE; prev_dma = o_DMA; prev_oe = o_ADDR_OE; prev_addr = o_ADDRESS;
    end
    task automatic check_idle(input string name);
        chk({name, "_ctl"}, {o_DMA, o_ADDR_OE, o_DATA_OE, o_RW, o_WE, o_wr_ready, o_busy, o_done, o_error},
            9'b100110000);
        chk({name, "_addr"}, o_ADDRESS, 0);
        chk({name, "_data"}, o_DATA, 0);
    endtask
    task automatic prep(input logic [15:0] b, input bit rnd);
        for (int i = 0; i < 256; i++) src[i] = rnd ? 8'($urandom) : 8'(8'hA0 + i);
        m_base = b;
        epoch++;
    endtask
    task automatic pulse_start(input logic [15:0] b, input logic [12:0] len);
        @(negedge clk);
        i_base_addr = b; i_length = len; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask
    task automatic wait_end(input int budget);
        int t = 0;
        while (done_cnt + err_cnt == 0 && t < budget) begin @(negedge clk); t++; end
        if (t >= budget) chk("end_timeout", 0, 1);
        repeat (4) @(negedge clk);
    endtask
    task automatic end_xfer(input int len);
        wait_end(20000);
        chk("n_writes", wcount, len);
        chk("n_consumed", k, len);
        chk("n_done", done_cnt, 1);
        chk("n_error", err_cnt, 0);
        chk("busy_end", o_busy, 0);
        chk("dma_end", o_DMA, 1);
    endtask
    task automatic xfer(input logic [15:0] b, input logic [12:0] len, input bit rnd);
        prep(b, rnd);
        pulse_start(b, len);
        end_xfer(len);
    endtask
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        xfer(16'h0100, 3, 1'b0);
        chk("basic_a0", wr_addr[0], 16'h0100);
        chk("basic_a2", wr_addr[2], 16'h0102);
        chk("basic_d1", wr_data[1], 8'hA1);
        chk("basic_d2", wr_data[2], 8'hA2);
        chk("basic_tenures", ten_q.size(), 1);
        prep(16'h0000, 1'b0);
        pulse_start(16'h0000, 13'd0);
        #1 chk("len0_done", o_done, 1);
        @(negedge clk);
        chk("len0_pulse", o_done, 0);
        repeat (20) @(negedge clk);
        chk("len0_dma", dma_falls, 0);
        chk("len0_done_cnt", done_cnt, 1);
        chk("len0_busy", o_busy, 0);
        xfer(16'h1000, 30, 1'b1);
        chk("burst_tenures", ten_q.size(), 3);
        if (ten_q.size() == 3) begin
            chk("burst_t0", ten_q[0], 14);
            chk("burst_t1", ten_q[1], 14);
            chk("burst_t2", ten_q[2], 2);
        end
        src_mode = 2;
        xfer(16'h0040, 4, 1'b1);
        chk("stall_tenures", ten_q.size(), 2);
        if (ten_q.size() == 2) chk("stall_t0", ten_q[0], 2);
        src_mode = 0;
        xfer(16'hFFFE, 3, 1'b1);
        chk("wrap_a1", wr_addr[1], 16'hFFFF);
        chk("wrap_a2", wr_addr[2], 16'h0000);
        prep(16'h0200, 1'b1);
        pulse_start(16'h0200, 5);
        repeat (6) @(negedge clk);
        chk("busy_mid", o_busy, 1);
        pulse_start(16'h0800, 2);
        end_xfer(5);
        for (int r = 0; r < 6; r++) begin
            grant_lat = $urandom_range(0, 6);
            src_mode = 1;
            xfer(16'($urandom), 13'($urandom_range(1, 40)), 1'b1);
        end
        src_mode = 0;
        grant_lat = 2;
        no_grant = 1'b1;
        prep(16'h0300, 1'b1);
        pulse_start(16'h0300, 5);
        wait_end(3000);
        chk("tmo_err_cnt", err_cnt, 1);
        chk("tmo_latency", err_cyc - dma_fall_cyc, TMO);
        chk("tmo_done", done_cnt, 0);
        chk("tmo_writes", wcount, 0);
        chk("tmo_busy", o_busy, 0);
        chk("tmo_dma", o_DMA, 1);
        no_grant = 1'b0;
        prep(16'h0400, 1'b1);
        pulse_start(16'h0400, 6);
        t = 0;
        while (o_WE && t < 200) begin @(negedge clk); t++; end
        chk("reach_strobe", o_WE, 0);
        reset = 1'b1;
        @(negedge clk);
        #1 check_idle("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        xfer(16'h0480, 5, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
